// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared encodings for the branch resolve stage
package branch_resolve_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    OPC_NONE,
    OPC_BRANCH,
    OPC_JAL,
    OPC_JALR
  } op_class_e;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } brs_state_e;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// rtl/branch_resolve_unit_cond.sv - combinational branch condition evaluator
module branch_cond
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken_cond,
  output logic            illegal
);

  // Decode funct3 into the six compares; reserved encodings flag illegal and never take.
  always_comb begin
    taken_cond = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_BEQ:  taken_cond = (rs1 == rs2);
      F3_BNE:  taken_cond = (rs1 != rs2);
      F3_BLT:  taken_cond = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken_cond = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken_cond = (rs1 <  rs2);
      F3_BGEU: taken_cond = (rs1 >= rs2);
      default: illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch/jump resolution with mispredict detection
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_branch,
  input  logic             op_jal,
  input  logic             op_jalr,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  link,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal,
  output logic             misalign,
  output logic [CNT_W-1:0] mispred_cnt
);

  brs_state_e      state_q, state_d;
  op_class_e       op_class;
  logic            taken_cond, illegal_cond;
  logic            taken_c, illegal_c, misalign_c, mispred_c;
  logic [XLEN-1:0] target_c, link_c;
  logic            capture;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .taken_cond (taken_cond),
    .illegal    (illegal_cond)
  );

  // Collapse the one-hot op flags into a single class for target selection.
  always_comb begin
    op_class = OPC_NONE;
    if (op_jalr)        op_class = OPC_JALR;
    else if (op_jal)    op_class = OPC_JAL;
    else if (op_branch) op_class = OPC_BRANCH;
  end

  // Resolve outcome, target and mispredict; trap cases (illegal/misalign) never redirect.
  always_comb begin
    link_c    = pc + XLEN'(4);
    illegal_c = (op_class == OPC_BRANCH) && illegal_cond;
    taken_c   = 1'b0;
    target_c  = link_c;
    case (op_class)
      OPC_BRANCH: begin
        taken_c  = taken_cond && !illegal_cond;
        target_c = pc + imm;
      end
      OPC_JAL: begin
        taken_c  = 1'b1;
        target_c = pc + imm;
      end
      OPC_JALR: begin
        taken_c  = 1'b1;
        target_c = (rs1 + imm) & ~XLEN'(1);
      end
      default: ;
    endcase
    misalign_c = taken_c && target_c[1];
    mispred_c  = !(misalign_c || illegal_c) &&
                 ((taken_c != pred_taken) || (taken_c && pred_taken && (target_c != pred_target)));
  end

  assign in_ready  = (state_q == ST_EMPTY) || out_ready;
  assign capture   = in_valid && in_ready && !flush;
  assign out_valid = (state_q == ST_FULL);

  // Occupancy of the one-entry output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy: flush wins, then capture refills, then a drain empties.
  always_comb begin
    state_d = state_q;
    if (flush)                                state_d = ST_EMPTY;
    else if (capture)                         state_d = ST_FULL;
    else if (state_q == ST_FULL && out_ready) state_d = ST_EMPTY;
  end

  // Result payload; only loaded on capture so it holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken       <= 1'b0;
      target      <= '0;
      link        <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      illegal     <= 1'b0;
      misalign    <= 1'b0;
    end else if (capture) begin
      taken       <= taken_c;
      target      <= target_c;
      link        <= link_c;
      mispredict  <= mispred_c;
      redirect_pc <= taken_c ? target_c : link_c;
      illegal     <= illegal_c;
      misalign    <= misalign_c;
    end
  end

  // Count mispredicts actually handed downstream; a flushed result is not delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mispred_cnt <= '0;
    else if (out_valid && out_ready && mispredict && !flush && (mispred_cnt != '1))
      mispred_cnt <= mispred_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - randomized self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  typedef struct packed {
    logic        taken;
    logic [63:0] target;
    logic [63:0] link;
    logic        misp;
    logic [63:0] redir;
    logic        ill;
    logic        mis;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        flush = 0, in_valid = 0, in_ready, op_branch = 0, op_jal = 0, op_jalr = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] rs1 = 0, rs2 = 0, pc = 0, imm = 0, pred_target = 0;
  logic        pred_taken = 0, out_valid, out_ready = 0;
  logic        taken, mispredict, illegal, misalign;
  logic [31:0] target, link, redirect_pc;
  logic [15:0] mispred_cnt;

  branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op_branch(op_branch), .op_jal(op_jal), .op_jalr(op_jalr), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .pred_taken(pred_taken), .pred_target(pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .target(target), .link(link),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .illegal(illegal), .misalign(misalign),
    .mispred_cnt(mispred_cnt)
  );

  // 64-bit instance with a narrow counter to reach saturation quickly
  logic        w_flush = 0, w_in_valid = 0, w_in_ready, w_op_branch = 0, w_op_jal = 0, w_op_jalr = 0;
  logic [2:0]  w_funct3 = 0;
  logic [63:0] w_rs1 = 0, w_rs2 = 0, w_pc = 0, w_imm = 0, w_pred_target = 0;
  logic        w_pred_taken = 0, w_out_valid, w_out_ready = 0;
  logic        w_taken, w_mispredict, w_illegal, w_misalign;
  logic [63:0] w_target, w_link, w_redirect_pc;
  logic [2:0]  w_mispred_cnt;

  branch_resolve_unit #(.XLEN(64), .CNT_W(3)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .op_branch(w_op_branch), .op_jal(w_op_jal), .op_jalr(w_op_jalr), .funct3(w_funct3),
    .rs1(w_rs1), .rs2(w_rs2), .pc(w_pc), .imm(w_imm), .pred_taken(w_pred_taken),
    .pred_target(w_pred_target), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .taken(w_taken), .target(w_target), .link(w_link), .mispredict(w_mispredict),
    .redirect_pc(w_redirect_pc), .illegal(w_illegal), .misalign(w_misalign),
    .mispred_cnt(w_mispred_cnt)
  );

  int   tests = 0;
  int   fails = 0;
  res_t q[$];
  int   cnt_exp = 0;
  int   delivered = 0;
  int   accepted_flag = 0;

  // Reference: cls 0=non-control 1=branch 2=jal 3=jalr; arithmetic wraps at width w.
  function automatic res_t model(int w, int cls, logic [2:0] f3, logic [63:0] a, logic [63:0] b,
                                 logic [63:0] p, logic [63:0] i, logic pt, logic [63:0] ptg);
    res_t r;
    logic [63:0] mask;
    logic lt_s, lt_u;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a = a & mask; b = b & mask;
    if (w == 64) lt_s = $signed(a) < $signed(b);
    else         lt_s = $signed(a[31:0]) < $signed(b[31:0]);
    lt_u = a < b;
    r = '0;
    r.link = (p + 64'd4) & mask;
    if (cls == 0) begin
      r.target = r.link;
    end else if (cls == 3) begin
      r.taken  = 1'b1;
      r.target = ((a + i) & mask) & ~64'd1;
    end else begin
      r.target = (p + i) & mask;
      if (cls == 2) r.taken = 1'b1;
      else begin
        case (f3)
          3'd0: r.taken = (a == b);
          3'd1: r.taken = (a != b);
          3'd4: r.taken = lt_s;
          3'd5: r.taken = !lt_s;
          3'd6: r.taken = lt_u;
          3'd7: r.taken = !lt_u;
          default: r.ill = 1'b1;
        endcase
      end
    end
    r.mis   = r.taken && r.target[1];
    r.misp  = !(r.mis || r.ill) &&
              ((r.taken != pt) || (r.taken && pt && (r.target != (ptg & mask))));
    r.redir = r.taken ? r.target : r.link;
    return r;
  endfunction

  function automatic int cls32();
    return op_jalr ? 3 : op_jal ? 2 : op_branch ? 1 : 0;
  endfunction

  task automatic set_op32(int cls, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                          logic [31:0] p, logic [31:0] i, logic pt, logic [31:0] ptg);
    op_branch = (cls == 1); op_jal = (cls == 2); op_jalr = (cls == 3);
    funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i; pred_taken = pt; pred_target = ptg;
  endtask

  task automatic rand_op32();
    int cls;
    res_t r;
    cls = $urandom_range(0, 3);
    set_op32(cls, 3'($urandom), $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
             32'($signed(12'($urandom))), 1'($urandom), $urandom);
    if ($urandom_range(0, 2) == 0) rs2 = rs1;
    if ($urandom_range(0, 1) == 0) begin
      r = model(32, cls, funct3, rs1, rs2, pc, imm, pred_taken, 0);
      pred_target = r.target[31:0];
    end
  endtask

  // One clock of the 32-bit unit: check against the scoreboard, then advance it.
  task automatic cycle32();
    logic exp_ir;
    res_t e;
    #1;
    exp_ir = (q.size() == 0) || out_ready;
    accepted_flag = 0;
    tests++;
    if (in_ready !== exp_ir) begin
      fails++; $display("FAIL in_ready: got %b want %b", in_ready, exp_ir);
    end
    tests++;
    if (out_valid !== (q.size() != 0)) begin
      fails++; $display("FAIL out_valid: got %b want %b", out_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      e = q[0];
      tests++;
      if ({taken, target, link, mispredict, redirect_pc, illegal, misalign} !==
          {e.taken, e.target[31:0], e.link[31:0], e.misp, e.redir[31:0], e.ill, e.mis}) begin
        fails++;
        $display("FAIL result: got t=%b tgt=%h lnk=%h mp=%b rd=%h il=%b ma=%b want t=%b tgt=%h lnk=%h mp=%b rd=%h il=%b ma=%b",
                 taken, target, link, mispredict, redirect_pc, illegal, misalign,
                 e.taken, e.target[31:0], e.link[31:0], e.misp, e.redir[31:0], e.ill, e.mis);
      end
    end
    tests++;
    if (mispred_cnt !== 16'(cnt_exp)) begin
      fails++; $display("FAIL mispred_cnt: got %0d want %0d", mispred_cnt, cnt_exp);
    end
    if (flush) q.delete();
    else begin
      if (q.size() != 0 && out_ready) begin
        if (q[0].misp && cnt_exp < 65535) cnt_exp++;
        void'(q.pop_front());
        delivered++;
      end
      if (in_valid && exp_ir) begin
        q.push_back(model(32, cls32(), funct3, rs1, rs2, pc, imm, pred_taken, pred_target));
        accepted_flag = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 0; flush = 0; out_ready = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    q.delete(); cnt_exp = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({out_valid, taken, mispredict, illegal, misalign, target, link, redirect_pc, mispred_cnt} !== '0) begin
      fails++; $display("FAIL reset_outputs: got v=%b t=%b tgt=%h lnk=%h cnt=%0d want all zero",
                        out_valid, taken, target, link, mispred_cnt);
    end
    cycle32();
  endtask

  task automatic test_directed();
    // BLT signed: -1 < 1
    set_op32(1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, 0);
    in_valid = 1; out_ready = 0; cycle32(); in_valid = 0; #1;
    tests++;
    if ({taken, mispredict} !== 2'b11) begin
      fails++; $display("FAIL blt_signed: got t=%b mp=%b want t=1 mp=1", taken, mispredict);
    end
    out_ready = 1; cycle32();
    // BLTU: 0xFFFFFFFF not below 1
    set_op32(1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, 0);
    in_valid = 1; out_ready = 0; cycle32(); in_valid = 0; #1;
    tests++;
    if ({taken, mispredict} !== 2'b00) begin
      fails++; $display("FAIL bltu_unsigned: got t=%b mp=%b want t=0 mp=0", taken, mispredict);
    end
    out_ready = 1; cycle32();
    // JALR with misaligned target
    set_op32(3, 3'b000, 32'h1001, 0, 32'h100, 32'h2, 1'b1, 32'h1002);
    in_valid = 1; out_ready = 0; cycle32(); in_valid = 0; #1;
    tests++;
    if ({target, misalign, mispredict, link} !== {32'h1002, 1'b1, 1'b0, 32'h104}) begin
      fails++; $display("FAIL jalr_misalign: got tgt=%h ma=%b mp=%b lnk=%h want tgt=1002 ma=1 mp=0 lnk=104",
                        target, misalign, mispredict, link);
    end
    out_ready = 1; cycle32();
  endtask

  task automatic test_beq_count();
    do_reset();
    set_op32(1, 3'b000, 32'd5, 32'd5, 32'h1000, 32'h80, 1'b1, 32'h1084);
    out_ready = 1; in_valid = 1;
    cycle32(); #1;
    tests++;
    if ({mispredict, redirect_pc} !== {1'b1, 32'h1080}) begin
      fails++; $display("FAIL beq_target_off: got mp=%b rd=%h want mp=1 rd=1080", mispredict, redirect_pc);
    end
    cycle32(); cycle32();
    in_valid = 0;
    cycle32(); cycle32();
    tests++;
    if (mispred_cnt !== 16'd3) begin
      fails++; $display("FAIL beq_cnt3: got %0d want 3", mispred_cnt);
    end
  endtask

  task automatic test_stream_stall();
    int sent = 0;
    int budget = 0;
    int start_del = delivered;
    out_ready = 1;
    rand_op32();
    while (sent < 8 && budget < 100) begin
      in_valid = 1;
      cycle32();
      out_ready = ~out_ready;
      if (accepted_flag != 0) begin
        sent++;
        rand_op32();
      end
      budget++;
    end
    in_valid = 0; out_ready = 1;
    cycle32(); cycle32();
    tests++;
    if (sent != 8 || delivered - start_del != 8) begin
      fails++; $display("FAIL stream8: sent %0d delivered %0d want 8 and 8", sent, delivered - start_del);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      rand_op32(); in_valid = 1; cycle32();
      tests++;
      if (accepted_flag == 0) begin
        fails++; $display("FAIL back_to_back: op %0d not accepted want accepted", i);
      end
    end
    in_valid = 0; cycle32();
  endtask

  task automatic test_flush();
    int cnt_before;
    set_op32(1, 3'b001, 32'd1, 32'd2, 32'h400, 32'h20, 1'b0, 0);
    in_valid = 1; out_ready = 0; cycle32();
    cnt_before = cnt_exp;
    rand_op32(); flush = 1; in_valid = 1; out_ready = 0; cycle32();
    flush = 0; in_valid = 0; #1;
    tests++;
    if (out_valid !== 1'b0 || mispred_cnt !== 16'(cnt_before)) begin
      fails++; $display("FAIL flush: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, mispred_cnt, cnt_before);
    end
    cycle32();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_op32();
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      cycle32();
    end
    flush = 0; in_valid = 0; out_ready = 1; cycle32();
  endtask

  task automatic test_reset_mid();
    set_op32(2, 3'b000, 0, 0, 32'h800, 32'h100, 1'b0, 0);
    in_valid = 1; out_ready = 0; cycle32(); in_valid = 0;
    rst_n = 1'b0; #1;
    tests++;
    if ({out_valid, taken, mispredict, illegal, misalign, target, link, redirect_pc, mispred_cnt} !== '0) begin
      fails++; $display("FAIL reset_mid: got v=%b t=%b tgt=%h lnk=%h cnt=%0d want all zero",
                        out_valid, taken, target, link, mispred_cnt);
    end
    q.delete(); cnt_exp = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    cycle32();
  endtask

  task automatic set_op64(int cls, logic [2:0] f3, logic [63:0] a, logic [63:0] b,
                          logic [63:0] p, logic [63:0] i, logic pt);
    w_op_branch = (cls == 1); w_op_jal = (cls == 2); w_op_jalr = (cls == 3);
    w_funct3 = f3; w_rs1 = a; w_rs2 = b; w_pc = p; w_imm = i; w_pred_taken = pt; w_pred_target = 0;
  endtask

  task automatic test_xlen64();
    res_t e;
    w_out_ready = 1;
    set_op64(0, 3'b000, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 1'b0);
    e = model(64, 0, w_funct3, w_rs1, w_rs2, w_pc, w_imm, w_pred_taken, w_pred_target);
    w_in_valid = 1; @(posedge clk); @(negedge clk); w_in_valid = 0; #1;
    tests++;
    if ({w_link, w_taken} !== {64'h0, 1'b0} || w_target !== e.target) begin
      fails++; $display("FAIL x64_link_wrap: got lnk=%h t=%b tgt=%h want lnk=0 t=0 tgt=%h",
                        w_link, w_taken, w_target, e.target);
    end
    set_op64(1, 3'b010, 64'd3, 64'd3, 64'h1000, 64'h8, 1'b1);
    w_in_valid = 1; @(posedge clk); @(negedge clk); w_in_valid = 0; #1;
    tests++;
    if ({w_illegal, w_taken, w_mispredict} !== 3'b100) begin
      fails++; $display("FAIL x64_illegal: got il=%b t=%b mp=%b want il=1 t=0 mp=0",
                        w_illegal, w_taken, w_mispredict);
    end
    set_op64(1, 3'b100, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_0000_0000, 64'h2000, 64'h40, 1'b0);
    e = model(64, 1, w_funct3, w_rs1, w_rs2, w_pc, w_imm, w_pred_taken, w_pred_target);
    w_in_valid = 1; @(posedge clk); @(negedge clk); w_in_valid = 0; #1;
    tests++;
    if ({w_taken, w_target, w_mispredict, w_redirect_pc} !== {e.taken, e.target, e.misp, e.redir}) begin
      fails++; $display("FAIL x64_blt: got t=%b tgt=%h mp=%b want t=%b tgt=%h mp=%b",
                        w_taken, w_target, w_mispredict, e.taken, e.target, e.misp);
    end
    @(posedge clk); @(negedge clk);
    tests++;
    if (w_mispred_cnt !== 3'd1) begin
      fails++; $display("FAIL x64_cnt1: got %0d want 1", w_mispred_cnt);
    end
    // non-control ops predicted taken each count as a mispredict
    set_op64(0, 3'b000, 0, 0, 64'h3000, 0, 1'b1);
    w_in_valid = 1;
    for (int i = 0; i < 4; i++) begin @(posedge clk); @(negedge clk); end
    w_in_valid = 0;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    tests++;
    if (w_mispred_cnt !== 3'd5) begin
      fails++; $display("FAIL x64_cnt5: got %0d want 5", w_mispred_cnt);
    end
    w_in_valid = 1;
    for (int i = 0; i < 6; i++) begin @(posedge clk); @(negedge clk); end
    w_in_valid = 0;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    tests++;
    if (w_mispred_cnt !== 3'd7) begin
      fails++; $display("FAIL x64_saturate: got %0d want 7", w_mispred_cnt);
    end
  endtask

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_beq_count();
    test_stream_stall();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid();
    test_xlen64();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
